// File: rtl/core_wb_arbiter_if.sv
// Write-back arbitration bundle: pipeline WB request, multi-cycle unit handshake,
// decode hazard query and the single register-file write port.
interface core_wb_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_issue_ready;
  logic        md_done;
  logic [31:0] md_wdata;
  logic        md_ack;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        flush;
  logic        reg_d_write;
  logic [4:0]  reg_d_addr;
  logic [31:0] reg_d_value;

  modport master (
    output pipe_valid, pipe_rd, pipe_wdata, md_issue, md_issue_rd, md_done, md_wdata,
           dec_rs1, dec_rs2, dec_rd, flush,
    input  pipe_stall, md_issue_ready, md_ack, hazard, reg_d_write, reg_d_addr, reg_d_value
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_wdata, md_issue, md_issue_rd, md_done, md_wdata,
           dec_rs1, dec_rs2, dec_rd, flush,
    output pipe_stall, md_issue_ready, md_ack, hazard, reg_d_write, reg_d_addr, reg_d_value
  );
endinterface

// File: rtl/core_wb_arbiter.sv
// Shares one register-file write port between the WB stage and a single outstanding
// multi-cycle op; buffered results win for one cycle, the pipeline otherwise writes at zero latency.
module core_wb_arbiter (
  input logic               clk,
  input logic               rst_n,
  core_wb_arbiter_if.slave  wb
);

  typedef enum logic [1:0] {IDLE, BUSY, READY, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [31:0] buf_data_q, buf_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_rd_q  <= 5'd0;
      buf_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      buf_data_q <= buf_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    buf_data_d = buf_data_q;
    case (state_q)
      IDLE: begin
        if (wb.md_issue && !wb.flush) begin
          state_d   = BUSY;
          pend_rd_d = wb.md_issue_rd;
        end
      end
      BUSY: begin
        // A flush that coincides with completion has nothing left to drain.
        if (wb.flush) begin
          state_d = wb.md_done ? IDLE : DRAIN;
        end else if (wb.md_done) begin
          state_d    = READY;
          buf_data_d = wb.md_wdata;
        end
      end
      READY:   state_d = IDLE;
      DRAIN:   if (wb.md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic        buf_win;
  logic        win_vld;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        rd_match;

  always_comb begin
    buf_win  = (state_q == READY) && !wb.flush;
    win_vld  = 1'b0;
    win_addr = 5'd0;
    win_data = 32'd0;
    if (buf_win) begin
      win_vld  = 1'b1;
      win_addr = pend_rd_q;
      win_data = buf_data_q;
    end else if (wb.pipe_valid) begin
      win_vld  = 1'b1;
      win_addr = wb.pipe_rd;
      win_data = wb.pipe_wdata;
    end

    rd_match = (wb.dec_rs1 == pend_rd_q) || (wb.dec_rs2 == pend_rd_q) ||
               (wb.dec_rd == pend_rd_q);

    wb.md_issue_ready = (state_q == IDLE);
    wb.md_ack         = wb.md_done && ((state_q == BUSY) || (state_q == DRAIN));
    wb.pipe_stall     = wb.pipe_valid && buf_win;
    wb.hazard         = ((state_q == BUSY) || (state_q == READY)) && (pend_rd_q != 5'd0) && rd_match;
    // x0 writes still take the grant but drive nothing onto the port.
    wb.reg_d_write    = win_vld && (win_addr != 5'd0);
    wb.reg_d_addr     = wb.reg_d_write ? win_addr : 5'd0;
    wb.reg_d_value    = wb.reg_d_write ? win_data : 32'd0;
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  core_wb_arbiter_if bus();

  core_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {md_issue_ready, md_ack, hazard, pipe_stall, reg_d_write}
  function automatic logic [4:0] flags();
    return {bus.md_issue_ready, bus.md_ack, bus.hazard, bus.pipe_stall, bus.reg_d_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_valid  = 1'b0;
    bus.pipe_rd     = 5'd0;
    bus.pipe_wdata  = 32'd0;
    bus.md_issue    = 1'b0;
    bus.md_issue_rd = 5'd0;
    bus.md_done     = 1'b0;
    bus.md_wdata    = 32'd0;
    bus.dec_rs1     = 5'd0;
    bus.dec_rs2     = 5'd0;
    bus.dec_rd      = 5'd0;
    bus.flush       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.md_done = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=%b", flags(), 5'b10000);
    end
    checks++;
    if (bus.reg_d_addr !== 5'd0 || bus.reg_d_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_port got addr=%0d val=%h exp 0/0", bus.reg_d_addr, bus.reg_d_value);
    end
    bus.md_done = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd5;
    #1;
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL basic_issue got=%b exp=%b", flags(), 5'b10000);
    end
    tick();
    bus.md_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (flags() !== 5'b00000) begin
        errors++;
        $display("FAIL basic_busy%0d got=%b exp=%b", i, flags(), 5'b00000);
      end
      tick();
    end
    bus.md_done = 1'b1;
    bus.md_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (flags() !== 5'b01000) begin
      errors++;
      $display("FAIL basic_ack got=%b exp=%b", flags(), 5'b01000);
    end
    tick();
    bus.md_done = 1'b0;
    #1;
    checks++;
    if (flags() !== 5'b00001 || bus.reg_d_addr !== 5'd5 || bus.reg_d_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_write got=%b addr=%0d val=%h exp=00001 addr=5 val=deadbeef",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    tick();
    #1;
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL basic_idle got=%b exp=%b", flags(), 5'b10000);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd5;
    tick();
    bus.md_issue = 1'b0;
    bus.md_done = 1'b1;
    bus.md_wdata = 32'hCAFE0005;
    tick();
    bus.md_done = 1'b0;
    bus.pipe_valid = 1'b1;
    bus.pipe_rd = 5'd7;
    bus.pipe_wdata = 32'h11;
    #1;
    checks++;
    if (flags() !== 5'b00011 || bus.reg_d_addr !== 5'd5 || bus.reg_d_value !== 32'hCAFE0005) begin
      errors++;
      $display("FAIL prio_buf got=%b addr=%0d val=%h exp=00011 addr=5 val=cafe0005",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    tick();
    #1;
    checks++;
    if (flags() !== 5'b10001 || bus.reg_d_addr !== 5'd7 || bus.reg_d_value !== 32'h11) begin
      errors++;
      $display("FAIL prio_pipe got=%b addr=%0d val=%h exp=10001 addr=7 val=11",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    tick();
  endtask

  task automatic test_hazard();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd3;
    tick();
    bus.md_issue = 1'b0;
    bus.dec_rs2 = 5'd3;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_rs2 got=%b exp=1", bus.hazard);
    end
    bus.dec_rs1 = 5'd4; bus.dec_rs2 = 5'd4; bus.dec_rd = 5'd4;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_nomatch got=%b exp=0", bus.hazard);
    end
    bus.dec_rd = 5'd3;
    bus.md_done = 1'b1;
    bus.md_wdata = 32'h3;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_rd got=%b exp=1", bus.hazard);
    end
    tick();
    bus.md_done = 1'b0;
    bus.dec_rd = 5'd4;
    bus.dec_rs1 = 5'd3;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_ready got=%b exp=1", bus.hazard);
    end
    tick();
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_idle got=%b exp=0", bus.hazard);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd9;
    tick();
    bus.md_issue = 1'b0;
    bus.flush = 1'b1;
    #1;
    checks++;
    if (flags() !== 5'b00000) begin
      errors++;
      $display("FAIL flush_busy got=%b exp=%b", flags(), 5'b00000);
    end
    tick();
    bus.flush = 1'b0;
    bus.dec_rs1 = 5'd9;
    #1;
    checks++;
    if (flags() !== 5'b00000) begin
      errors++;
      $display("FAIL flush_drain got=%b exp=%b", flags(), 5'b00000);
    end
    tick();
    bus.md_done = 1'b1;
    bus.md_wdata = 32'h99;
    #1;
    checks++;
    if (flags() !== 5'b01000) begin
      errors++;
      $display("FAIL flush_ack got=%b exp=%b", flags(), 5'b01000);
    end
    tick();
    bus.md_done = 1'b0;
    #1;
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL flush_idle got=%b exp=%b", flags(), 5'b10000);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd0;
    tick();
    bus.md_issue = 1'b0;
    bus.md_done = 1'b1;
    bus.md_wdata = 32'h55;
    #1;
    checks++;
    if (flags() !== 5'b01000) begin
      errors++;
      $display("FAIL x0_ack got=%b exp=%b", flags(), 5'b01000);
    end
    tick();
    bus.md_done = 1'b0;
    bus.pipe_valid = 1'b1;
    bus.pipe_rd = 5'd2;
    bus.pipe_wdata = 32'h77;
    #1;
    checks++;
    if (flags() !== 5'b00010 || bus.reg_d_addr !== 5'd0 || bus.reg_d_value !== 32'd0) begin
      errors++;
      $display("FAIL x0_grant got=%b addr=%0d val=%h exp=00010 addr=0 val=0",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    tick();
    #1;
    checks++;
    if (flags() !== 5'b10001 || bus.reg_d_addr !== 5'd2 || bus.reg_d_value !== 32'h77) begin
      errors++;
      $display("FAIL x0_pipe got=%b addr=%0d val=%h exp=10001 addr=2 val=77",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd6;
    tick();
    bus.md_issue = 1'b0;
    bus.md_done = 1'b1;
    bus.md_wdata = 32'hABCD;
    tick();
    bus.md_done = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (flags() !== 5'b10000 || bus.reg_d_addr !== 5'd0 || bus.reg_d_value !== 32'd0) begin
      errors++;
      $display("FAIL rst_ready got=%b addr=%0d val=%h exp=10000 addr=0 val=0",
               flags(), bus.reg_d_addr, bus.reg_d_value);
    end
    bus.md_issue = 1'b1;
    bus.md_issue_rd = 5'd4;
    tick();
    bus.md_issue = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.md_done = 1'b1;
    bus.dec_rs1 = 5'd4;
    #1;
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL rst_busy_noack got=%b exp=%b", flags(), 5'b10000);
    end
    tick();
    bus.md_done = 1'b0;
  endtask

  // Reference: tracks the outstanding op as a few flags rather than named states.
  bit          m_inflight, m_killed, m_buffered;
  logic [4:0]  m_pend;
  logic [31:0] m_buf;

  task automatic test_random();
    bit          e_rdy, e_ack, e_haz, e_stall, e_wr, bwin, wv;
    logic [4:0]  e_addr, wa;
    logic [31:0] e_val, wd;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    m_inflight = 0; m_killed = 0; m_buffered = 0; m_pend = '0; m_buf = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n           = ($urandom_range(0, 39) != 0);
      bus.md_issue    = ($urandom_range(0, 2) == 0);
      bus.md_issue_rd = 5'($urandom_range(0, 7));
      bus.md_done     = ($urandom_range(0, 3) == 0);
      bus.md_wdata    = $urandom;
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.pipe_valid  = ($urandom_range(0, 1) == 0);
      bus.pipe_rd     = 5'($urandom_range(0, 7));
      bus.pipe_wdata  = $urandom;
      bus.dec_rs1     = 5'($urandom_range(0, 7));
      bus.dec_rs2     = 5'($urandom_range(0, 7));
      bus.dec_rd      = 5'($urandom_range(0, 7));

      e_rdy   = !m_inflight && !m_buffered;
      e_ack   = bus.md_done && m_inflight;
      bwin    = m_buffered && !bus.flush;
      e_stall = bus.pipe_valid && bwin;
      e_haz   = ((m_inflight && !m_killed) || m_buffered) && m_pend != 0 &&
                (bus.dec_rs1 == m_pend || bus.dec_rs2 == m_pend || bus.dec_rd == m_pend);
      wv = bwin || bus.pipe_valid;
      wa = bwin ? m_pend : bus.pipe_rd;
      wd = bwin ? m_buf : bus.pipe_wdata;
      e_wr   = wv && wa != 0;
      e_addr = e_wr ? wa : 5'd0;
      e_val  = e_wr ? wd : 32'd0;
      #1;
      checks++;
      if ({bus.md_issue_ready, bus.md_ack, bus.hazard, bus.pipe_stall, bus.reg_d_write} !==
          {e_rdy, e_ack, e_haz, e_stall, e_wr}) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, flags(),
                 {e_rdy, e_ack, e_haz, e_stall, e_wr});
      end
      checks++;
      if (bus.reg_d_addr !== e_addr || bus.reg_d_value !== e_val) begin
        errors++;
        $display("FAIL rnd_port cyc=%0d got addr=%0d val=%h exp addr=%0d val=%h",
                 cyc, bus.reg_d_addr, bus.reg_d_value, e_addr, e_val);
      end

      if (!rst_n) begin
        m_inflight = 0; m_killed = 0; m_buffered = 0; m_pend = '0; m_buf = '0;
      end else if (m_buffered) begin
        m_buffered = 0;
      end else if (m_inflight) begin
        if (m_killed) begin
          if (bus.md_done) m_inflight = 0;
        end else if (bus.flush) begin
          if (bus.md_done) m_inflight = 0;
          else m_killed = 1;
        end else if (bus.md_done) begin
          m_inflight = 0;
          m_buffered = 1;
          m_buf = bus.md_wdata;
        end
      end else if (bus.md_issue && !bus.flush) begin
        m_inflight = 1;
        m_killed = 0;
        m_pend = bus.md_issue_rd;
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_basic();
    test_priority();
    test_hazard();
    test_flush();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: pipe_valid  input  1  WB-stage instruction requests a register write; pipe_rd  input  5  its destination; pipe_wdata  input  32  its value.
REQ-004 SHALL have port: pipe_stall  output  1  WB stage SHALL hold its instruction this cycle.
REQ-005 SHALL have ports: md_issue  input  1  multi-cycle op issued; md_issue_rd  input  5  its destination; md_issue_ready  output  1  an issue can be accepted.
REQ-006 SHALL have ports: md_done  input  1  multi-cycle result valid, held until acked; md_wdata  input  32  result; md_ack  output  1  result consumed.
REQ-007 SHALL have ports: dec_rs1, dec_rs2, dec_rd  input  5 each  decode-stage register indices; hazard  output  1  decode SHALL stall.
REQ-008 SHALL have port: flush  input  1  kill any outstanding multi-cycle op.
REQ-009 SHALL have ports: reg_d_write  output  1; reg_d_addr  output  5; reg_d_value  output  32  single register-file write port.

Function
REQ-010 SHALL implement a 4-state FSM: IDLE, BUSY (op in flight), READY (result buffered), DRAIN (killed op in flight).
REQ-011 SHALL hold pend_rd (5 b) and buf_data (32 b) registers.
REQ-012 IDLE: md_issue & !flush -> BUSY, pend_rd <= md_issue_rd; md_issue & flush -> issue dropped, stay IDLE.
REQ-013 md_issue_ready SHALL be 1 only in IDLE; md_issue outside IDLE SHALL be ignored.
REQ-014 BUSY: md_done & !flush -> READY, buf_data <= md_wdata; flush (regardless of md_done) -> DRAIN if !md_done, IDLE if md_done.
REQ-015 md_ack SHALL equal md_done & (state==BUSY | state==DRAIN), combinational; md_done in IDLE/READY SHALL not be acked.
REQ-016 DRAIN: md_done -> IDLE, result discarded; otherwise stay; flush has no further effect.
REQ-017 READY: buffered result SHALL drive write port this cycle -> IDLE; flush in READY -> IDLE with no write.
REQ-018 Port priority: READY-buffer (not flushed) over pipeline; pipe_stall = pipe_valid & (state==READY) & !flush; else pipeline writes same cycle (zero latency).
REQ-019 reg_d_addr/reg_d_value SHALL come from winning source; reg_d_write = winner exists & addr != 0 (x0 writes suppressed, still consume the grant).
REQ-020 hazard = (state==BUSY | state==READY) & pend_rd!=0 & (dec_rs1==pend_rd | dec_rs2==pend_rd | dec_rd==pend_rd); 0 in IDLE/DRAIN.
REQ-021 pipe_stall SHALL be 0 in IDLE, BUSY, DRAIN; never more than one consecutive stall cycle per buffered result.
REQ-022 Unused reg_d_addr/reg_d_value when reg_d_write=0 SHALL be 0.

Reset
REQ-023 rst_n=0 at clock edge SHALL force IDLE, pend_rd=0, buf_data=0; outputs then: md_issue_ready=1, md_ack=0, hazard=0, pipe_stall=0, reg_d_write=0.
REQ-024 Reset mid-operation (BUSY/READY/DRAIN) SHALL discard the op; later md_done SHALL not be acked until a new issue.

Verification
REQ-025 Issue rd=5, md_done after 4 cycles with 0xDEADBEEF -> md_ack that cycle, next cycle reg_d_write=1 addr=5 value=0xDEADBEEF, IDLE.
REQ-026 READY while pipe_valid rd=7 value=0x11 -> cycle1 write rd=5 pipe_stall=1; cycle2 write rd=7 0x11 pipe_stall=0.
REQ-027 BUSY rd=3, dec_rs2=3 -> hazard=1; dec_rs1=dec_rs2=dec_rd=4 -> hazard=0; pend_rd=0 -> hazard=0 always.
REQ-028 Flush in BUSY, md_done 2 cycles later -> DRAIN, md_ack=1, no register write, IDLE, md_issue_ready=1.
REQ-029 Issue rd=0, result 0x55 -> grant consumed, reg_d_write=0.
REQ-030 rst_n=0 in READY -> next cycle IDLE, no write of buffered data, all outputs at REQ-023 values.
